pipeline_ctrl: RTL and testbench

Central sequencing controller for the 5-stage 16-bit CPU.
- Owns the run/idle `state` signal consumed by every pipeline stage.
- Resolves control hazards: flushes on branches and jumps taken in MEM.
- Resolves load-use data hazards: stalls IF/ID for one cycle and inserts an EX bubble.
- Drains the pipeline cleanly on HALT, and counts executed cycles for debug.

---
 rtl/pipeline_ctrl_pkg.sv | 41 ++++
 rtl/pipeline_ctrl_hazard_detect.sv | 50 +++++
 rtl/pipeline_ctrl.sv | 95 +++++++++
 tb/tb_pipeline_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared opcode map, exec/idle encoding and instruction field helpers
// for the 5-stage 16-bit CPU control path.
package pipeline_ctrl_pkg;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_LOAD  = 5'd5;
  localparam logic [4:0] OP_STORE = 5'd6;
  localparam logic [4:0] OP_JUMP  = 5'd7;
  localparam logic [4:0] OP_JMPR  = 5'd8;
  localparam logic [4:0] OP_BZ    = 5'd9;
  localparam logic [4:0] OP_BNZ   = 5'd10;
  localparam logic [4:0] OP_BN    = 5'd11;
  localparam logic [4:0] OP_BNN   = 5'd12;
  localparam logic [4:0] OP_BC    = 5'd13;
  localparam logic [4:0] OP_BNC   = 5'd14;
  localparam logic [4:0] OP_HALT  = 5'd31;

  localparam logic ST_EXEC = 1'b1;
  localparam logic ST_IDLE = 1'b0;

  function automatic logic [4:0] op_of(input logic [15:0] ir);
    return ir[15:11];
  endfunction

  function automatic logic [2:0] r1_of(input logic [15:0] ir);
    return ir[10:8];
  endfunction

  function automatic logic [2:0] r2_of(input logic [15:0] ir);
    return ir[6:4];
  endfunction

  function automatic logic [2:0] r3_of(input logic [15:0] ir);
    return ir[2:0];
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational hazard detection: load-use in ID/EX and branch resolution in MEM.
// Outputs are unqualified; the controller gates them with its active state.
import pipeline_ctrl_pkg::*;

module hazard_detect (
  input  logic [15:0] id_ir,
  input  logic [15:0] ex_ir,
  input  logic [15:0] mem_ir,
  input  logic        zf,
  input  logic        nf,
  input  logic        cf,
  output logic        hazard,
  output logic        taken
);

  logic [4:0] id_op, ex_op, mem_op;
  logic [2:0] ex_r1;
  logic       uses_r23, uses_r1;
  logic       unused_bits;

  assign id_op  = op_of(id_ir);
  assign ex_op  = op_of(ex_ir);
  assign mem_op = op_of(mem_ir);
  assign ex_r1  = r1_of(ex_ir);

  // r1 is a destination for most ops; STORE and JMPR read it as a source
  assign uses_r23 = !(id_op inside {OP_NOP, OP_HALT, OP_JUMP});
  assign uses_r1  = id_op inside {OP_STORE, OP_JMPR};

  assign hazard = (ex_op == OP_LOAD) &&
                  ((uses_r23 && (ex_r1 == r2_of(id_ir) || ex_r1 == r3_of(id_ir))) ||
                   (uses_r1  && (ex_r1 == r1_of(id_ir))));

  always_comb begin
    taken = 1'b0;
    case (mem_op)
      OP_JUMP, OP_JMPR: taken = 1'b1;
      OP_BZ:            taken = zf;
      OP_BNZ:           taken = !zf;
      OP_BN:            taken = nf;
      OP_BNN:           taken = !nf;
      OP_BC:            taken = cf;
      OP_BNC:           taken = !cf;
      default:          taken = 1'b0;
    endcase
  end

  assign unused_bits = ^{id_ir[7], id_ir[3], ex_ir[7:0], mem_ir[10:0]};

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer: run/idle FSM, HALT drain, flush/stall arbitration
// and the debug cycle counter.
import pipeline_ctrl_pkg::*;

module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  input  logic [15:0]      id_ir,
  input  logic [15:0]      ex_ir,
  input  logic [15:0]      mem_ir,
  input  logic             zf,
  input  logic             nf,
  input  logic             cf,
  output logic             state,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush,
  output logic             branch_taken,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DCW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} fsm_t;

  fsm_t           fsm;
  logic [DCW-1:0] drain_cnt;
  logic           active, hazard, taken, taken_q, hazard_q, halt_id;

  hazard_detect u_hazard (
    .id_ir  (id_ir),
    .ex_ir  (ex_ir),
    .mem_ir (mem_ir),
    .zf     (zf),
    .nf     (nf),
    .cf     (cf),
    .hazard (hazard),
    .taken  (taken)
  );

  assign active   = (fsm inside {S_RUN, S_DRAIN}) && enable;
  assign taken_q  = active && taken;
  assign hazard_q = active && hazard && !taken_q;
  // HALT in ID is ignored while stalled or when a flush removes it
  assign halt_id  = (op_of(id_ir) == OP_HALT) && !hazard_q && !taken_q;

  assign state        = active ? ST_EXEC : ST_IDLE;
  assign flush        = taken_q;
  assign branch_taken = taken_q;
  assign stall_if     = hazard_q;
  assign stall_id     = hazard_q;
  assign bubble_ex    = hazard_q;
  assign halted       = (fsm == S_HALTED);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm         <= S_IDLE;
      drain_cnt   <= '0;
      cycle_count <= '0;
    end else begin
      if (active) cycle_count <= cycle_count + CNT_W'(1);
      case (fsm)
        S_IDLE, S_HALTED: if (start) begin
          fsm         <= S_RUN;
          cycle_count <= '0;
        end
        S_RUN: if (active && halt_id) begin
          fsm       <= S_DRAIN;
          drain_cnt <= DCW'(DRAIN_CYCLES);
        end
        S_DRAIN: if (active) begin
          // a taken branch means the HALT was speculative
          if (taken_q) begin
            fsm       <= S_RUN;
            drain_cnt <= '0;
          end else if (drain_cnt <= DCW'(1)) begin
            fsm       <= S_HALTED;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt - DCW'(1);
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
import pipeline_ctrl_pkg::*;

module tb_pipeline_ctrl;

  logic        clock, reset, start, enable;
  logic [15:0] id_ir, ex_ir, mem_ir;
  logic        zf, nf, cf;
  logic        state, stall_if, stall_id, bubble_ex, flush, branch_taken, halted;
  logic [15:0] cycle_count;

  int n_cmp = 0;
  int n_bad = 0;

  pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .enable(enable),
    .id_ir(id_ir), .ex_ir(ex_ir), .mem_ir(mem_ir),
    .zf(zf), .nf(nf), .cf(cf),
    .state(state), .stall_if(stall_if), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .flush(flush), .branch_taken(branch_taken),
    .halted(halted), .cycle_count(cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural reference model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3;
  int m_mode = M_IDLE;
  int m_rem  = 0;
  int m_cnt  = 0;

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] a, b, c);
    return {op, a, 1'b0, b, 1'b0, c};
  endfunction

  function automatic bit f_taken(input logic [15:0] ir, input bit z, n, c);
    int op;
    op = int'(ir >> 11);
    return op == OP_JUMP || op == OP_JMPR ||
           (op == OP_BZ && z) || (op == OP_BNZ && !z) ||
           (op == OP_BN && n) || (op == OP_BNN && !n) ||
           (op == OP_BC && c) || (op == OP_BNC && !c);
  endfunction

  function automatic bit f_hazard(input logic [15:0] id, input logic [15:0] ex);
    int srcs[$];
    int op, dst;
    op  = int'(id >> 11);
    dst = int'((ex >> 8) & 16'h7);
    if (int'(ex >> 11) != OP_LOAD) return 0;
    if (op != OP_NOP && op != OP_HALT && op != OP_JUMP) begin
      srcs.push_back(int'((id >> 4) & 16'h7));
      srcs.push_back(int'(id & 16'h7));
    end
    if (op == OP_STORE || op == OP_JMPR) srcs.push_back(int'((id >> 8) & 16'h7));
    foreach (srcs[i]) if (srcs[i] == dst) return 1;
    return 0;
  endfunction

  function automatic bit m_active();
    return (m_mode == M_RUN || m_mode == M_DRAIN) && enable;
  endfunction

  task automatic m_advance();
    bit a, tk, hz;
    a  = m_active();
    tk = a && f_taken(mem_ir, zf, nf, cf);
    hz = a && !tk && f_hazard(id_ir, ex_ir);
    if (a) m_cnt = (m_cnt + 1) % 65536;
    case (m_mode)
      M_IDLE, M_HALT: if (start) begin m_mode = M_RUN; m_cnt = 0; end
      M_RUN: if (a && !tk && !hz && int'(id_ir >> 11) == OP_HALT) begin
        m_mode = M_DRAIN; m_rem = 3;
      end
      default: if (a) begin
        if (tk) m_mode = M_RUN;
        else begin
          m_rem--;
          if (m_rem == 0) m_mode = M_HALT;
        end
      end
    endcase
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string name);
    bit a, tk, hz;
    a  = m_active();
    tk = a && f_taken(mem_ir, zf, nf, cf);
    hz = a && !tk && f_hazard(id_ir, ex_ir);
    chk({name, ".outs"},
        32'({state, stall_if, stall_id, bubble_ex, flush, branch_taken, halted}),
        32'({a, hz, hz, hz, tk, tk, m_mode == M_HALT}));
    chk({name, ".cnt"}, 32'(cycle_count), 32'(m_cnt));
  endtask

  // inputs are already applied after a negedge; check, then clock once
  task automatic step(input string name);
    #1 chk_model(name);
    m_advance();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_ir(input logic [15:0] id, ex, mem);
    id_ir = id; ex_ir = ex; mem_ir = mem;
  endtask

  typedef struct {
    logic [15:0] id, ex, mem;
    logic        z, n, c;
    logic        exp_stall, exp_flush;
  } vec_t;

  vec_t tbl[15];

  initial begin
    reset = 1'b1; start = 1'b0; enable = 1'b0;
    zf = 0; nf = 0; cf = 0;
    set_ir(16'h0, 16'h0, 16'h0);

    tbl[0]  = '{mk(OP_NOP,0,0,0), mk(OP_NOP,0,0,0), mk(OP_BZ,0,0,0),   1,0,0, 0,1};
    tbl[1]  = '{mk(OP_NOP,0,0,0), mk(OP_NOP,0,0,0), mk(OP_BZ,0,0,0),   0,0,0, 0,0};
    tbl[2]  = '{mk(OP_NOP,0,0,0), mk(OP_NOP,0,0,0), mk(OP_BNC,0,0,0),  0,0,0, 0,1};
    tbl[3]  = '{mk(OP_NOP,0,0,0), mk(OP_NOP,0,0,0), mk(OP_BNC,0,0,0),  0,0,1, 0,0};
    tbl[4]  = '{mk(OP_NOP,0,0,0), mk(OP_NOP,0,0,0), mk(OP_BN,0,0,0),   0,1,0, 0,1};
    tbl[5]  = '{mk(OP_NOP,0,0,0), mk(OP_NOP,0,0,0), mk(OP_BNN,0,0,0),  0,1,0, 0,0};
    tbl[6]  = '{mk(OP_NOP,0,0,0), mk(OP_NOP,0,0,0), mk(OP_BC,0,0,0),   0,0,1, 0,1};
    tbl[7]  = '{mk(OP_NOP,0,0,0), mk(OP_NOP,0,0,0), mk(OP_BNZ,0,0,0),  0,0,0, 0,1};
    tbl[8]  = '{mk(OP_NOP,0,0,0), mk(OP_NOP,0,0,0), mk(OP_JMPR,1,0,0), 0,0,0, 0,1};
    tbl[9]  = '{mk(OP_ADD,3,2,1), mk(OP_LOAD,2,0,0), mk(OP_JUMP,0,0,0), 0,0,0, 0,1};
    tbl[10] = '{mk(OP_STORE,5,0,1), mk(OP_LOAD,5,0,0), mk(OP_NOP,0,0,0), 0,0,0, 1,0};
    tbl[11] = '{mk(OP_ADD,5,0,1), mk(OP_LOAD,5,0,0), mk(OP_NOP,0,0,0),  0,0,0, 0,0};
    tbl[12] = '{mk(OP_JUMP,0,1,1), mk(OP_LOAD,1,0,0), mk(OP_NOP,0,0,0), 0,0,0, 0,0};
    tbl[13] = '{mk(OP_JMPR,3,0,0), mk(OP_LOAD,3,0,0), mk(OP_NOP,0,0,0), 0,0,0, 1,0};
    tbl[14] = '{mk(OP_ADD,0,2,0), mk(OP_ADD,2,0,0), mk(OP_NOP,0,0,0),   0,0,0, 0,0};

    // reset state
    repeat (2) @(negedge clock);
    chk("reset.outs", 32'({state, stall_if, stall_id, bubble_ex, flush, branch_taken, halted}), 0);
    chk("reset.cnt", 32'(cycle_count), 0);
    reset = 1'b0;

    // start, then 10 active cycles
    start = 1'b1; enable = 1'b1;
    step("start");
    start = 1'b0;
    chk("start.state", 32'(state), 1);
    chk("start.cnt0", 32'(cycle_count), 0);
    for (int i = 0; i < 10; i++) step("run");
    chk("run.cnt10", 32'(cycle_count), 10);

    // load-use stall lasts one cycle
    set_ir(mk(OP_ADD,3,2,1), mk(OP_LOAD,2,0,0), mk(OP_NOP,0,0,0));
    #1 chk("loaduse.stall", 32'({stall_if, stall_id, bubble_ex}), 32'h7);
    step("loaduse.c0");
    set_ir(mk(OP_ADD,3,2,1), mk(OP_NOP,0,0,0), mk(OP_LOAD,2,0,0));
    #1 chk("loaduse.after", 32'({stall_if, stall_id, bubble_ex}), 0);
    step("loaduse.c1");

    // directed vector table
    foreach (tbl[i]) begin
      set_ir(tbl[i].id, tbl[i].ex, tbl[i].mem);
      zf = tbl[i].z; nf = tbl[i].n; cf = tbl[i].c;
      #1;
      chk($sformatf("tbl%0d.stall", i), 32'({stall_if, stall_id, bubble_ex}),
          tbl[i].exp_stall ? 32'h7 : 32'h0);
      chk($sformatf("tbl%0d.flush", i), 32'({flush, branch_taken}),
          tbl[i].exp_flush ? 32'h3 : 32'h0);
      step($sformatf("tbl%0d", i));
    end
    zf = 0; nf = 0; cf = 0;

    // HALT drains for 3 active cycles then halts with a frozen counter
    set_ir(mk(OP_HALT,0,0,0), 16'h0, 16'h0);
    step("halt.decode");
    set_ir(16'h0, 16'h0, 16'h0);
    enable = 1'b0;
    step("halt.frozen");
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drain%0d.halted", i), 32'(halted), 0);
      step("drain");
    end
    chk("halted.flag", 32'(halted), 1);
    chk("halted.state", 32'(state), 0);
    for (int i = 0; i < 3; i++) step("halted.hold");

    // restart, then a taken branch during DRAIN returns to RUN
    start = 1'b1;
    step("restart");
    start = 1'b0;
    chk("restart.cnt", 32'(cycle_count), 0);
    set_ir(mk(OP_HALT,0,0,0), 16'h0, 16'h0);
    step("halt2.decode");
    set_ir(16'h0, 16'h0, 16'h0);
    step("drain2");
    mem_ir = mk(OP_BZ,0,0,0); zf = 1'b1;
    #1 chk("drainbr.flush", 32'({flush, branch_taken}), 32'h3);
    step("drainbr");
    mem_ir = 16'h0; zf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("drainbr.nohalt", 32'({halted, state}), 32'h1);
      step("drainbr.run");
    end

    // asynchronous reset mid-DRAIN
    set_ir(mk(OP_HALT,0,0,0), 16'h0, 16'h0);
    step("halt3.decode");
    set_ir(16'h0, 16'h0, 16'h0);
    #1 reset = 1'b1;
    #1;
    m_mode = M_IDLE; m_cnt = 0; m_rem = 0;
    chk("arst.outs", 32'({state, stall_if, stall_id, bubble_ex, flush, branch_taken, halted}), 0);
    chk("arst.cnt", 32'(cycle_count), 0);
    @(negedge clock);
    reset = 1'b0;
    step("arst.idle");

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [4:0] ops[8];
      ops = '{OP_ADD, OP_LOAD, OP_STORE, OP_JMPR, OP_BZ, OP_BNC, OP_NOP, OP_JUMP};
      start  = ($urandom_range(0, 15) == 0);
      enable = ($urandom_range(0, 7) != 0);
      id_ir  = ($urandom_range(0, 15) == 0) ? mk(OP_HALT,0,0,0)
             : mk(ops[$urandom_range(0,7)], 3'($urandom_range(0,3)),
                  3'($urandom_range(0,3)), 3'($urandom_range(0,3)));
      ex_ir  = mk(($urandom_range(0,1) == 1) ? OP_LOAD : OP_ADD,
                  3'($urandom_range(0,3)), 3'd0, 3'd0);
      mem_ir = ($urandom_range(0, 3) == 0)
             ? mk(5'($urandom_range(OP_JUMP, OP_BNC)), 0, 0, 0) : 16'h0;
      zf = 1'($urandom); nf = 1'($urandom); cf = 1'($urandom);
      step($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
